// File: rtl/vga_image_scanout_pkg.sv
// vga_image_scanout_pkg: 640x480 raster timing, 160x120 source size and zoom geometry,
// shared by the scanout and the decimation stage.
package vga_image_scanout_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SRC_W    = 160;
    localparam int SRC_H    = 120;

    typedef struct packed {
        logic [9:0] w;
        logic [9:0] h;
        logic [9:0] x0;
        logic [9:0] y0;
    } img_geom_t;

    function automatic img_geom_t zoom_geom(input logic [2:0] zoom);
        img_geom_t g;
        g.w  = (zoom == 3'd0) ? 10'd40 : (zoom == 3'd1) ? 10'd80 : 10'(SRC_W);
        g.h  = (zoom == 3'd0) ? 10'd30 : (zoom == 3'd1) ? 10'd60 : 10'(SRC_H);
        g.x0 = (10'(H_ACTIVE) - g.w) >> 1;
        g.y0 = (10'(V_ACTIVE) - g.h) >> 1;
        return g;
    endfunction
endpackage

// File: rtl/vga_image_scanout_timing.sv
// vga_timing: free-running 800x525 raster counters with raw, unpipelined sync and active decode.
module vga_timing
    import vga_image_scanout_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] o_h_cnt,
    output logic [9:0] o_v_cnt,
    output logic       o_hs_n,
    output logic       o_vs_n,
    output logic       o_active,
    output logic       o_origin
);
    logic [9:0] r_h_cnt, r_v_cnt;
    logic       w_h_last, w_v_last;

    assign w_h_last = r_h_cnt == 10'(H_TOTAL - 1);
    assign w_v_last = r_v_cnt == 10'(V_TOTAL - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_h_cnt <= w_h_last ? '0 : r_h_cnt + 10'd1;
            if (w_h_last)
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
        end
    end

    assign o_h_cnt  = r_h_cnt;
    assign o_v_cnt  = r_v_cnt;
    assign o_hs_n   = !(r_h_cnt >= 10'(H_ACTIVE + H_FP) && r_h_cnt < 10'(H_ACTIVE + H_FP + H_SYNC));
    assign o_vs_n   = !(r_v_cnt >= 10'(V_ACTIVE + V_FP) && r_v_cnt < 10'(V_ACTIVE + V_FP + V_SYNC));
    assign o_active = r_h_cnt < 10'(H_ACTIVE) && r_v_cnt < 10'(V_ACTIVE);
    assign o_origin = r_h_cnt == '0 && r_v_cnt == '0;
endmodule

// File: rtl/vga_image_scanout.sv
// vga_image_scanout: centres a zoom-selected greyscale frame-buffer image on a 640x480 VGA raster.
// Define SCANOUT_BORDER_EN to draw a one-pixel BORDER_COLOR outline around the image.
module vga_image_scanout
    import vga_image_scanout_pkg::*;
#(
    parameter int         FB_ADDR_W    = 19,
    parameter logic [7:0] BORDER_COLOR = 8'hFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           zoom_level,
    input  logic                 frame_done,
    input  logic [7:0]           fb_data,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [7:0]           vga_r,
    output logic [7:0]           vga_g,
    output logic [7:0]           vga_b,
    output logic                 vga_hs,
    output logic                 vga_vs,
    output logic                 vga_blank_n,
    output logic                 frame_start
);
    logic [9:0]           w_h, w_v;
    logic                 w_hs_n, w_vs_n, w_active, w_origin;
    img_geom_t            w_geom;
    logic                 w_in_img, w_last;
    logic [7:0]           w_ring_pix, w_pix;
    logic [FB_ADDR_W-1:0] r_addr;
    logic [2:0]           r_zoom;
    logic                 r_buf_valid, r_frame_valid;
    logic                 r_s1_blank_n, r_s1_hs, r_s1_vs, r_s1_fs, r_s1_pix;

    vga_timing u_timing (
        .clk      (clk),
        .reset    (reset),
        .o_h_cnt  (w_h),
        .o_v_cnt  (w_v),
        .o_hs_n   (w_hs_n),
        .o_vs_n   (w_vs_n),
        .o_active (w_active),
        .o_origin (w_origin)
    );

    // Geometry comes from the zoom latched at the frame origin, so mid-frame changes wait a frame.
    assign w_geom   = zoom_geom(r_zoom);
    assign w_in_img = w_h >= w_geom.x0 && w_h < w_geom.x0 + w_geom.w &&
                      w_v >= w_geom.y0 && w_v < w_geom.y0 + w_geom.h;
    assign w_last   = w_h == w_geom.x0 + w_geom.w - 10'd1 && w_v == w_geom.y0 + w_geom.h - 10'd1;
    assign fb_addr  = r_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr        <= '0;
            r_zoom        <= 3'd2;
            r_buf_valid   <= 1'b0;
            r_frame_valid <= 1'b0;
        end else begin
            if (frame_done)
                r_buf_valid <= 1'b1;
            if (w_origin) begin
                r_zoom        <= zoom_level;
                r_frame_valid <= r_buf_valid | frame_done;
                r_addr        <= '0;
            end else if (w_in_img && !w_last) begin
                r_addr <= r_addr + FB_ADDR_W'(1);
            end
        end
    end

`ifdef SCANOUT_BORDER_EN
    logic w_ring, r_s1_ring;
    assign w_ring = !w_in_img &&
                    w_h >= w_geom.x0 - 10'd1 && w_h <= w_geom.x0 + w_geom.w &&
                    w_v >= w_geom.y0 - 10'd1 && w_v <= w_geom.y0 + w_geom.h;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_s1_ring <= 1'b0;
        else
            r_s1_ring <= w_ring;
    end
    assign w_ring_pix = r_s1_ring ? BORDER_COLOR : 8'h00;
`else
    assign w_ring_pix = BORDER_COLOR & 8'h00;
`endif

    assign w_pix = !r_s1_blank_n ? 8'h00 : r_s1_pix ? fb_data : w_ring_pix;

    // Stage 1 aligns with the RAM read, stage 2 with the returned pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_blank_n <= 1'b0;
            r_s1_hs      <= 1'b1;
            r_s1_vs      <= 1'b1;
            r_s1_fs      <= 1'b0;
            r_s1_pix     <= 1'b0;
            vga_r        <= 8'h00;
            vga_g        <= 8'h00;
            vga_b        <= 8'h00;
            vga_hs       <= 1'b1;
            vga_vs       <= 1'b1;
            vga_blank_n  <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            r_s1_blank_n <= w_active;
            r_s1_hs      <= w_hs_n;
            r_s1_vs      <= w_vs_n;
            r_s1_fs      <= w_origin;
            r_s1_pix     <= w_in_img && r_frame_valid;
            vga_r        <= w_pix;
            vga_g        <= w_pix;
            vga_b        <= w_pix;
            vga_hs       <= r_s1_hs;
            vga_vs       <= r_s1_vs;
            vga_blank_n  <= r_s1_blank_n;
            frame_start  <= r_s1_fs;
        end
    end
endmodule
